scaled_delay_timer: RTL and testbench

Multi-channel programmable delay timer that takes delays expressed as fixed-point values in a coarse time unit and converts them to an integer count of fine precision ticks, rounding to nearest. Each channel counts down independently and pulses `done` on expiry. An optional free-running time counter reports current time in precision ticks and in rounded whole units. It sits between a controller issuing fractional-unit delay requests and a fabric-wide precision tick enable.

---
 rtl/scaled_delay_timer.sv | 171 +++++++++++++++++
 tb/tb_scaled_delay_timer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scaled_delay_timer.sv
// Multi-channel delay timer: fixed-point unit delays rounded to precision ticks; SCALED_DELAY_TIMER_NOW_EN adds a time counter.
// Latency: accepted request loads its channel two edges later; sat pulses the cycle after accept.
// Backpressure: req_ready drops while the target channel is busy or already queued in the convert stage.
module scaled_delay_timer #(
  parameter int CHANNELS = 4,
  parameter int INT_W    = 8,
  parameter int FRAC_W   = 16,
  parameter int SCALE    = 10,
  parameter int CNT_W    = 32,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    tick,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [CH_W-1:0]         req_chan,
  input  logic [INT_W+FRAC_W-1:0] req_delay,
  input  logic [CHANNELS-1:0]     cancel,
  output logic [CHANNELS-1:0]     busy,
  output logic [CHANNELS-1:0]     done,
  output logic                    sat,
  output logic [CNT_W-1:0]        now_ticks,
  output logic [CNT_W-1:0]        now_units
);

  localparam int DLY_W = INT_W + FRAC_W;
  localparam int SC_W  = $clog2(SCALE) + 1;
  // Wide enough for the full product plus rounding term and any CNT_W.
  localparam int W     = DLY_W + SC_W + 1 + CNT_W;

  typedef enum logic {
    S_IDLE,
    S_COUNT
  } ch_state_t;

  logic [W-1:0]     prod;
  logic [W-1:0]     conv_full;
  logic [W-1:0]     cnt_max;
  logic             conv_sat;
  logic [CNT_W-1:0] conv_ticks;
  logic             accept;

  logic             c_vld;
  logic [CH_W-1:0]  c_chan;
  logic [CNT_W-1:0] c_ticks;

  ch_state_t        state_q [CHANNELS];
  ch_state_t        state_d [CHANNELS];
  logic [CNT_W-1:0] cnt_q   [CHANNELS];
  logic [CNT_W-1:0] cnt_d   [CHANNELS];
  logic [CHANNELS-1:0] done_d;
  logic [CHANNELS-1:0] done_q;

  assign prod       = W'(req_delay) * W'(SCALE) + (W'(1) << (FRAC_W - 1));
  assign conv_full  = prod >> FRAC_W;
  assign cnt_max    = W'({CNT_W{1'b1}});
  assign conv_sat   = conv_full > cnt_max;
  assign conv_ticks = conv_sat ? {CNT_W{1'b1}} : conv_full[CNT_W-1:0];

  always_comb begin
    req_ready = 1'b0;
    if (int'(req_chan) < CHANNELS) begin
      req_ready = !busy[req_chan] && !(c_vld && (c_chan == req_chan));
    end
  end

  assign accept = req_valid && req_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      c_vld   <= 1'b0;
      c_chan  <= '0;
      c_ticks <= '0;
      sat     <= 1'b0;
    end else begin
      c_vld <= accept;
      sat   <= accept && conv_sat;
      if (accept) begin
        c_chan  <= req_chan;
        c_ticks <= conv_ticks;
      end
    end
  end

  // Load beats cancel; cancel beats the expiring tick.
  always_comb begin
    done_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      if (c_vld && (c_chan == CH_W'(c))) begin
        if (c_ticks == '0) begin
          state_d[c] = S_IDLE;
          done_d[c]  = 1'b1;
        end else begin
          state_d[c] = S_COUNT;
          cnt_d[c]   = c_ticks;
        end
      end else if (state_q[c] == S_COUNT) begin
        if (cancel[c]) begin
          state_d[c] = S_IDLE;
        end else if (tick) begin
          if (cnt_q[c] == CNT_W'(1)) begin
            state_d[c] = S_IDLE;
            done_d[c]  = 1'b1;
          end else begin
            cnt_d[c] = cnt_q[c] - CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= S_IDLE;
        cnt_q[c]   <= '0;
      end
    end else begin
      done_q <= done_d;
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      busy[c] = (state_q[c] == S_COUNT);
    end
  end

  assign done = done_q;

`ifdef SCALED_DELAY_TIMER_NOW_EN
  localparam int SUB_W = $clog2(SCALE);

  logic [CNT_W-1:0] ticks_q;
  logic [CNT_W-1:0] unit_q;
  logic [SUB_W-1:0] sub_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ticks_q <= '0;
      unit_q  <= '0;
      sub_q   <= '0;
    end else if (tick) begin
      ticks_q <= ticks_q + CNT_W'(1);
      if (sub_q == SUB_W'(SCALE - 1)) begin
        sub_q  <= '0;
        unit_q <= unit_q + CNT_W'(1);
      end else begin
        sub_q <= sub_q + SUB_W'(1);
      end
    end
  end

  // Round half up: bump when the fractional part reaches half a unit.
  assign now_ticks = ticks_q;
  assign now_units = unit_q + CNT_W'({sub_q, 1'b0} >= (SUB_W + 1)'(SCALE));
`else
  assign now_ticks = '0;
  assign now_units = '0;
`endif

endmodule

// File: tb/tb_scaled_delay_timer.sv
// Directed bench for scaled_delay_timer: default instance plus a CNT_W=4 instance for saturation.
module tb_scaled_delay_timer;

`ifdef SCALED_DELAY_TIMER_NOW_EN
  localparam bit NOW_ON = 1'b1;
`else
  localparam bit NOW_ON = 1'b0;
`endif

  logic        clock;
  logic        reset_n;
  logic        tick;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_chan;
  logic [23:0] req_delay;
  logic [3:0]  cancel;
  logic [3:0]  busy;
  logic [3:0]  done;
  logic        sat;
  logic [31:0] now_ticks;
  logic [31:0] now_units;

  logic        s_req_valid;
  logic        s_req_ready;
  logic [1:0]  s_req_chan;
  logic [23:0] s_req_delay;
  logic [3:0]  s_cancel;
  logic [3:0]  s_busy;
  logic [3:0]  s_done;
  logic        s_sat;
  logic [3:0]  s_now_ticks;
  logic [3:0]  s_now_units;

  int n_checks;
  int n_fail;

  scaled_delay_timer u_dut (
    .clock(clock), .reset_n(reset_n), .tick(tick),
    .req_valid(req_valid), .req_ready(req_ready), .req_chan(req_chan), .req_delay(req_delay),
    .cancel(cancel), .busy(busy), .done(done), .sat(sat),
    .now_ticks(now_ticks), .now_units(now_units)
  );

  scaled_delay_timer #(.CNT_W(4)) u_sat (
    .clock(clock), .reset_n(reset_n), .tick(tick),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_chan(s_req_chan), .req_delay(s_req_delay),
    .cancel(s_cancel), .busy(s_busy), .done(s_done), .sat(s_sat),
    .now_ticks(s_now_ticks), .now_units(s_now_units)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    tick = 1'b0; req_valid = 1'b0; cancel = '0; s_req_valid = 1'b0;
    step;
    step;
    reset_n = 1'b1;
    step;
  endtask

  task automatic test_reset;
    reset_n = 1'b1;
    tick = 1'b0; req_valid = 1'b0; req_chan = '0; req_delay = '0; cancel = '0;
    s_req_valid = 1'b0; s_req_chan = '0; s_req_delay = '0; s_cancel = '0;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (busy !== 4'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0000", busy); end
    n_checks++; if (done !== 4'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0000", done); end
    n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b expected 0", sat); end
    n_checks++; if (now_ticks !== 32'd0) begin n_fail++; $display("FAIL reset_now_ticks: got %0d expected 0", now_ticks); end
    n_checks++; if (now_units !== 32'd0) begin n_fail++; $display("FAIL reset_now_units: got %0d expected 0", now_units); end
    n_checks++; if (s_busy !== 4'b0) begin n_fail++; $display("FAIL reset_sat_inst_busy: got %b expected 0000", s_busy); end
    step;
    step;
    reset_n = 1'b1;
    step;
  endtask

  task automatic test_basic;
    int cyc;
    bit seen;
    do_reset;
    req_chan = 2'd0; req_delay = 24'h022000; req_valid = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b expected 1", req_ready); end
    step;
    req_valid = 1'b0;
    n_checks++; if (busy !== 4'b0000) begin n_fail++; $display("FAIL basic_busy_before_load: got %b expected 0000", busy); end
    step;
    n_checks++; if (busy !== 4'b0001) begin n_fail++; $display("FAIL basic_busy_at_load: got %b expected 0001", busy); end
    tick = 1'b1;
    cyc = 1; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step;
      if (done[0]) seen = 1'b1;
      else if (busy[0]) cyc++;
    end
    tick = 1'b0;
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL basic_done_timeout: got %b expected 1", seen); end
    n_checks++; if (cyc != 21) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 21", cyc); end
    n_checks++; if (done !== 4'b0001) begin n_fail++; $display("FAIL basic_done_vec: got %b expected 0001", done); end
    n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall: got %b expected 0", busy[0]); end
    n_checks++; if (now_ticks !== (NOW_ON ? 32'd21 : 32'd0)) begin n_fail++; $display("FAIL basic_now_ticks: got %0d expected %0d", now_ticks, NOW_ON ? 21 : 0); end
    n_checks++; if (now_units !== (NOW_ON ? 32'd2 : 32'd0)) begin n_fail++; $display("FAIL basic_now_units: got %0d expected %0d", now_units, NOW_ON ? 2 : 0); end
    step;
    n_checks++; if (done !== 4'b0000) begin n_fail++; $display("FAIL basic_done_one_cycle: got %b expected 0000", done); end
  endtask

  task automatic test_rounding;
    logic [23:0] dly [4];
    int expt [4];
    int n;
    bit seen;
    dly  = '{24'h004000, 24'h001000, 24'h000C00, 24'h018000};
    expt = '{3, 1, 0, 15};
    for (int i = 0; i < 4; i++) begin
      req_chan = 2'd1; req_delay = dly[i]; req_valid = 1'b1;
      #1;
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL round_ready[%0d]: got %b expected 1", i, req_ready); end
      step;
      req_valid = 1'b0;
      n_checks++; if (busy[1] !== 1'b0) begin n_fail++; $display("FAIL round_busy_pre[%0d]: got %b expected 0", i, busy[1]); end
      step;
      if (expt[i] == 0) begin
        n_checks++; if (done[1] !== 1'b1) begin n_fail++; $display("FAIL round_zero_done[%0d]: got %b expected 1", i, done[1]); end
        n_checks++; if (busy[1] !== 1'b0) begin n_fail++; $display("FAIL round_zero_busy[%0d]: got %b expected 0", i, busy[1]); end
        step;
        n_checks++; if (done[1] !== 1'b0) begin n_fail++; $display("FAIL round_zero_done_clear[%0d]: got %b expected 0", i, done[1]); end
      end else begin
        n_checks++; if (busy[1] !== 1'b1) begin n_fail++; $display("FAIL round_busy_load[%0d]: got %b expected 1", i, busy[1]); end
        tick = 1'b1;
        n = 0; seen = 1'b0;
        for (int j = 0; j < 64 && !seen; j++) begin
          step;
          n++;
          if (done[1]) seen = 1'b1;
        end
        tick = 1'b0;
        n_checks++; if (!seen || n != expt[i]) begin n_fail++; $display("FAIL round_ticks[%0d]: got %0d expected %0d", i, seen ? n : -1, expt[i]); end
        step;
      end
    end
  endtask

  task automatic test_saturate;
    logic [23:0] dly [2];
    int expt_sat [2];
    int n;
    bit seen;
    dly = '{24'h020000, 24'h018000};
    expt_sat = '{1, 0};
    for (int i = 0; i < 2; i++) begin
      s_req_chan = 2'd0; s_req_delay = dly[i]; s_req_valid = 1'b1;
      #1;
      n_checks++; if (s_req_ready !== 1'b1) begin n_fail++; $display("FAIL sat_ready[%0d]: got %b expected 1", i, s_req_ready); end
      step;
      s_req_valid = 1'b0;
      n_checks++; if (s_sat !== expt_sat[i][0]) begin n_fail++; $display("FAIL sat_pulse[%0d]: got %b expected %0d", i, s_sat, expt_sat[i]); end
      step;
      n_checks++; if (s_sat !== 1'b0) begin n_fail++; $display("FAIL sat_pulse_clear[%0d]: got %b expected 0", i, s_sat); end
      n_checks++; if (s_busy[0] !== 1'b1) begin n_fail++; $display("FAIL sat_busy[%0d]: got %b expected 1", i, s_busy[0]); end
      tick = 1'b1;
      n = 0; seen = 1'b0;
      for (int j = 0; j < 64 && !seen; j++) begin
        step;
        n++;
        if (s_done[0]) seen = 1'b1;
      end
      tick = 1'b0;
      n_checks++; if (!seen || n != 15) begin n_fail++; $display("FAIL sat_ticks[%0d]: got %0d expected 15", i, seen ? n : -1); end
      step;
    end
    n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL sat_main_quiet: got %b expected 0", sat); end
  endtask

  task automatic test_back_to_back;
    logic [23:0] dly [4];
    int order [4];
    int expo [4];
    int k;
    bit ready_bad;
    dly  = '{24'h050000, 24'h030000, 24'h070000, 24'h010000};
    expo = '{3, 1, 0, 2};
    order = '{-1, -1, -1, -1};
    tick = 1'b0;
    req_valid = 1'b1;
    for (int ch = 0; ch < 4; ch++) begin
      req_chan = 2'(ch); req_delay = dly[ch];
      #1;
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected 1", ch, req_ready); end
      step;
      if (ch == 0) begin
        req_chan = 2'd0;
        #1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stage_c_block: got %b expected 0", req_ready); end
      end
    end
    req_valid = 1'b0;
    step;
    n_checks++; if (busy !== 4'b1111) begin n_fail++; $display("FAIL b2b_all_busy: got %b expected 1111", busy); end
    req_chan = 2'd2; req_delay = 24'h001000; req_valid = 1'b1;
    tick = 1'b1;
    k = 0; ready_bad = 1'b0;
    for (int i = 0; i < 200 && k < 4; i++) begin
      step;
      for (int c = 0; c < 4; c++) begin
        if (done[c] && k < 4) begin
          order[k] = c;
          k++;
        end
      end
      if (busy[2] && req_ready) ready_bad = 1'b1;
      if (done[2]) begin
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_done: got %b expected 1", req_ready); end
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    tick = 1'b0;
    n_checks++; if (ready_bad) begin n_fail++; $display("FAIL b2b_ready_while_busy: got 1 expected 0"); end
    n_checks++; if (k != 4) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 4", k); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (order[i] != expo[i]) begin n_fail++; $display("FAIL b2b_order[%0d]: got %0d expected %0d", i, order[i], expo[i]); end
    end
    step;
  endtask

  task automatic test_cancel;
    bit bad;
    // cancel at count 4
    req_chan = 2'd1; req_delay = 24'h010000; req_valid = 1'b1;
    step;
    req_valid = 1'b0;
    step;
    tick = 1'b1;
    repeat (6) step;
    n_checks++; if (busy[1] !== 1'b1) begin n_fail++; $display("FAIL cancel_busy_pre: got %b expected 1", busy[1]); end
    cancel = 4'b0010;
    step;
    cancel = '0;
    n_checks++; if (busy[1] !== 1'b0) begin n_fail++; $display("FAIL cancel_busy_post: got %b expected 0", busy[1]); end
    bad = done[1];
    repeat (12) begin
      step;
      if (done[1]) bad = 1'b1;
    end
    tick = 1'b0;
    n_checks++; if (bad) begin n_fail++; $display("FAIL cancel_no_done: got 1 expected 0"); end
    // cancel on the final tick
    req_chan = 2'd1; req_delay = 24'h001000; req_valid = 1'b1;
    step;
    req_valid = 1'b0;
    step;
    n_checks++; if (busy[1] !== 1'b1) begin n_fail++; $display("FAIL cancel_final_busy: got %b expected 1", busy[1]); end
    tick = 1'b1; cancel = 4'b0010;
    step;
    tick = 1'b0; cancel = '0;
    n_checks++; if (done[1] !== 1'b0) begin n_fail++; $display("FAIL cancel_final_done: got %b expected 0", done[1]); end
    n_checks++; if (busy[1] !== 1'b0) begin n_fail++; $display("FAIL cancel_final_busy_post: got %b expected 0", busy[1]); end
    step;
    n_checks++; if (done[1] !== 1'b0) begin n_fail++; $display("FAIL cancel_final_done_late: got %b expected 0", done[1]); end
    // cancel coinciding with load
    req_chan = 2'd2; req_delay = 24'h001000; req_valid = 1'b1;
    step;
    req_valid = 1'b0;
    cancel = 4'b0100;
    step;
    cancel = '0;
    n_checks++; if (busy[2] !== 1'b1) begin n_fail++; $display("FAIL cancel_load_wins: got %b expected 1", busy[2]); end
    tick = 1'b1;
    step;
    tick = 1'b0;
    n_checks++; if (done[2] !== 1'b1) begin n_fail++; $display("FAIL cancel_load_done: got %b expected 1", done[2]); end
    step;
  endtask

  task automatic test_now;
    do_reset;
    tick = 1'b1;
    repeat (24) step;
    n_checks++; if (now_ticks !== (NOW_ON ? 32'd24 : 32'd0)) begin n_fail++; $display("FAIL now_ticks_24: got %0d expected %0d", now_ticks, NOW_ON ? 24 : 0); end
    n_checks++; if (now_units !== (NOW_ON ? 32'd2 : 32'd0)) begin n_fail++; $display("FAIL now_units_24: got %0d expected %0d", now_units, NOW_ON ? 2 : 0); end
    step;
    tick = 1'b0;
    n_checks++; if (now_ticks !== (NOW_ON ? 32'd25 : 32'd0)) begin n_fail++; $display("FAIL now_ticks_25: got %0d expected %0d", now_ticks, NOW_ON ? 25 : 0); end
    n_checks++; if (now_units !== (NOW_ON ? 32'd3 : 32'd0)) begin n_fail++; $display("FAIL now_units_25: got %0d expected %0d", now_units, NOW_ON ? 3 : 0); end
    step;
    n_checks++; if (now_ticks !== (NOW_ON ? 32'd25 : 32'd0)) begin n_fail++; $display("FAIL now_ticks_hold: got %0d expected %0d", now_ticks, NOW_ON ? 25 : 0); end
  endtask

  task automatic test_reset_mid;
    bit bad;
    do_reset;
    req_chan = 2'd0; req_delay = 24'h050000; req_valid = 1'b1;
    step;
    req_valid = 1'b0;
    step;
    tick = 1'b1;
    repeat (10) step;
    n_checks++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_pre: got %b expected 1", busy[0]); end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (busy !== 4'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0000", busy); end
    n_checks++; if (done !== 4'b0) begin n_fail++; $display("FAIL rstmid_done: got %b expected 0000", done); end
    n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL rstmid_sat: got %b expected 0", sat); end
    n_checks++; if (now_ticks !== 32'd0) begin n_fail++; $display("FAIL rstmid_now_ticks: got %0d expected 0", now_ticks); end
    n_checks++; if (now_units !== 32'd0) begin n_fail++; $display("FAIL rstmid_now_units: got %0d expected 0", now_units); end
    step;
    reset_n = 1'b1;
    bad = 1'b0;
    repeat (60) begin
      step;
      if (done[0] || busy[0]) bad = 1'b1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL rstmid_dropped: got activity expected none"); end
    tick = 1'b0;
    // a request sitting in the convert stage is dropped too
    req_chan = 2'd1; req_delay = 24'h010000; req_valid = 1'b1;
    step;
    req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    step;
    n_checks++; if (busy !== 4'b0) begin n_fail++; $display("FAIL rstmid_stage_c_drop: got %b expected 0000", busy); end
    step;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset;
    test_basic;
    test_rounding;
    test_saturate;
    test_back_to_back;
    test_cancel;
    test_now;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
